mpsoc_ahb3_ext_responder: RTL and testbench
===========================================

// Module: mpsoc_ahb3_ext_responder
// PURPOSE
//  AHB3-Lite subordinate answering the MPSoC's external AHB3 master port (ahb3_ext_*).
//  Bench/FPGA-side endpoint: byte-addressable local RAM, programmable wait states,
//  ERROR response on out-of-range/misaligned/oversized transfers.
//  Sits outside mpsoc3d_riscv. Drives hrdata/hreadyout/hresp back into the system.
// PARAMETERS
//  PLEN         32           address width
//  XLEN         32           data width (only 32 supported)
//  MEM_WORDS    1024         RAM depth in XLEN words (power of 2)
//  BASE_ADDR    32'h8000_0000  first byte address decoded
//  WAIT_STATES  0            extra hreadyout-low cycles per OKAY transfer (0..15)
// PORTS
//  clk               in   1     clock
//  rst               in   1     synchronous reset, active-low
//  ahb3_hsel_i       in   1     subordinate select
//  ahb3_haddr_i      in   PLEN  address (address phase)
//  ahb3_hwdata_i     in   XLEN  write data (data phase)
//  ahb3_hwrite_i     in   1     1=write
//  ahb3_hsize_i      in   3     transfer size
//  ahb3_hburst_i     in   3     burst type (accepted, ignored)
//  ahb3_hprot_i      in   4     protection (accepted, ignored)
//  ahb3_htrans_i     in   2     IDLE/BUSY/NONSEQ/SEQ
//  ahb3_hmastlock_i  in   1     locked (accepted, ignored)
//  ahb3_hready_i     in   1     bus-level HREADY
//  ahb3_hrdata_o     out  XLEN  read data
//  ahb3_hreadyout_o  out  1     transfer done
//  ahb3_hresp_o      out  1     0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset (rst==0 at posedge): hreadyout=1, hresp=0, hrdata=0, state=IDLE; RAM not cleared.
//  Accept: hsel & hready_i & htrans[1] at posedge latches haddr/hwrite/hsize -> data phase.
//   IDLE/BUSY or hsel=0: no transfer, next cycle hreadyout=1 hresp=0.
//  Checks at accept: err = haddr<BASE | haddr>=BASE+4*MEM_WORDS | hsize>2 |
//   (hsize==1 & haddr[0]) | (hsize==2 & haddr[1:0]!=0).
//  FSM: IDLE -> WAIT (WAIT_STATES>0, ok) | DATA (WAIT_STATES==0, ok) | ERR1 (err).
//   WAIT: hreadyout=0; 4-bit counter from WAIT_STATES-1 down; at 0 -> DATA.
//   DATA: hreadyout=1 hresp=0; write commits this cycle; new accept -> WAIT/DATA/ERR1 else IDLE.
//   ERR1: hreadyout=0 hresp=1 -> ERR2.  ERR2: hreadyout=1 hresp=1; new accept allowed.
//  Errored transfers never write RAM; hrdata undefined-but-driven (hold last value).
//  Write: byte enables from hsize/haddr[1:0] (byte: 1<<a, half: 3<<a, word: 4'hF);
//   hwdata sampled in DATA cycle, RAM updated at that posedge. Lanes not enabled untouched.
//  Read: RAM read at accept (registered); hrdata valid in DATA cycle, full word returned.
//  Hazard: read accepted in same cycle as prior write's DATA commit to same word ->
//   forward merged bytes (write lanes from hwdata, rest from RAM). Zero-wait back-to-back
//   transfers sustain 1 transfer/cycle.
//  Word index = (haddr-BASE)[log2(MEM_WORDS)+1:2]; no wrap, out-of-range -> ERROR.
//  Reset mid-transfer: pending write dropped, FSM to IDLE, outputs to reset values.
//  hready_i low while in DATA (other subordinate stalls): no new accept that cycle.
// STRUCTURE
//  Package mpsoc_ahb3_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HWORD/WORD,
//   HRESP_OKAY/ERROR, responder state enum.
//  Sub-module mpsoc_ahb3_ram_1rw: 1 read + 1 write port, per-byte write enables,
//   registered read; forwarding mux lives in the responder.
// TESTING
//  1 WAIT_STATES=0: NONSEQ write word 0x8000_0010=0xDEADBEEF then read -> hrdata 0xDEADBEEF, hresp=0, 1 cycle each.
//  2 Byte write 0xA5 @0x8000_0013 then word read @0x8000_0010 -> 0xA5ADBEEF.
//  3 Back-to-back write 0x1234_5678 / read same addr, zero wait -> forwarded 0x1234_5678.
//  4 WAIT_STATES=3: read -> hreadyout low exactly 3 cycles, then high with data.
//  5 Access 0x8000_1000 (MEM_WORDS=1024) or half @0x8000_0001 -> ERR1(rdy0,resp1), ERR2(rdy1,resp1), RAM unchanged.
//  6 Assert rst low during WAIT of a write -> next cycle hreadyout=1 hresp=0, readback shows old data.

Source files
------------

// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings and decode helpers for the external-port responder.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // WAIT and ERR1 are the only states that hold hreadyout low.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } resp_state_t;

  // Byte-lane enables of a 32-bit transfer.
  function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] a);
    logic [3:0] be;
    case (hsize)
      HSIZE_BYTE:  be = 4'b0001 << a;
      HSIZE_HWORD: be = 4'b0011 << a;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Size wider than the bus, or address not aligned to the transfer size.
  function automatic logic size_err(input logic [2:0] hsize, input logic [1:0] a);
    return (hsize > HSIZE_WORD) ||
           ((hsize == HSIZE_HWORD) && a[0]) ||
           ((hsize == HSIZE_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mpsoc_ahb3_ram_1rw.sv
// Word-wide RAM: one registered read port, one write port with per-byte enables.
// Latency: read data appears the cycle after rd_en; writes land at the same posedge.
// Backpressure: none; always ready. Read of a word being written returns the old value.
// Ports: clk; rd_en/rd_addr -> rd_dat (held while rd_en low); wr_be/wr_addr/wr_dat.
module mpsoc_ahb3_ram_1rw
  #(parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS),
    parameter int DW    = 32)
  (
    input  logic            clk,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_dat,
    input  logic [DW/8-1:0] wr_be,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_dat
  );

  logic [DW-1:0] mem [WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
    for (int i = 0; i < DW/8; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mpsoc_ahb3_ext_responder.sv
// AHB3-Lite subordinate for the MPSoC external master port: local RAM, wait states, ERROR.
// Latency: OKAY transfers take 1+WAIT_STATES data-phase cycles; ERROR takes 2 cycles.
// Backpressure: hreadyout low during wait states and ERR1; no new accept unless hready_i high.
// Ports: clk, rst (sync, active-low); ahb3_* address/control/wdata in; hrdata/hreadyout/hresp out.
module mpsoc_ahb3_ext_responder
  import mpsoc_ahb3_pkg::*;
  #(parameter int              PLEN        = 32,
    parameter int              XLEN        = 32,
    parameter int              MEM_WORDS   = 1024,
    parameter logic [PLEN-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int              WAIT_STATES = 0)
  (
    input  logic            clk,
    input  logic            rst,
    input  logic            ahb3_hsel_i,
    input  logic [PLEN-1:0] ahb3_haddr_i,
    input  logic [XLEN-1:0] ahb3_hwdata_i,
    input  logic            ahb3_hwrite_i,
    input  logic [2:0]      ahb3_hsize_i,
    input  logic [2:0]      ahb3_hburst_i,
    input  logic [3:0]      ahb3_hprot_i,
    input  logic [1:0]      ahb3_htrans_i,
    input  logic            ahb3_hmastlock_i,
    input  logic            ahb3_hready_i,
    output logic [XLEN-1:0] ahb3_hrdata_o,
    output logic            ahb3_hreadyout_o,
    output logic            ahb3_hresp_o
  );

  localparam int            AW      = $clog2(MEM_WORDS);
  localparam logic [PLEN:0] LIMIT   = {1'b0, BASE_ADDR} + ((PLEN+1)'(MEM_WORDS) << 2);
  localparam logic [3:0]    WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_t state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;

  logic            can_accept, accept, err_now, fwd_hit, commit, rd_en;
  logic [PLEN-1:0] offset;
  logic [AW-1:0]   idx_now, idx_q;
  logic [3:0]      be_now, be_q, wr_be;
  logic            hwrite_q;

  logic            fwd_vld_q;
  logic [3:0]      fwd_be_q;
  logic [XLEN-1:0] fwd_dat_q;
  logic [XLEN-1:0] ram_rd_dat, rd_merged, hrdata_q;

  // Address-phase decode
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = can_accept && ahb3_hsel_i && ahb3_hready_i && ahb3_htrans_i[1];

  assign offset  = ahb3_haddr_i - BASE_ADDR;
  assign idx_now = offset[AW+1:2];
  assign be_now  = byte_en(ahb3_hsize_i, ahb3_haddr_i[1:0]);
  assign err_now = ({1'b0, ahb3_haddr_i} < {1'b0, BASE_ADDR}) ||
                   ({1'b0, ahb3_haddr_i} >= LIMIT) ||
                   size_err(ahb3_hsize_i, ahb3_haddr_i[1:0]);

  // Write commits in the DATA cycle; gating with rst drops it if reset lands there.
  assign commit = (state_q == ST_DATA) && hwrite_q && rst;
  assign wr_be  = commit ? be_q : 4'b0000;

  assign rd_en  = accept && !err_now && !ahb3_hwrite_i;

  // The RAM read issued at this posedge misses the write committing at the same posedge,
  // so remember the written lanes and patch them into the returned word.
  assign fwd_hit = rd_en && commit && (idx_now == idx_q);

  mpsoc_ahb3_ram_1rw #(.WORDS(MEM_WORDS), .AW(AW), .DW(XLEN)) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (idx_now),
    .rd_dat  (ram_rd_dat),
    .wr_be   (wr_be),
    .wr_addr (idx_q),
    .wr_dat  (ahb3_hwdata_i)
  );

  always_comb begin
    rd_merged = ram_rd_dat;
    for (int i = 0; i < 4; i++) begin
      if (fwd_vld_q && fwd_be_q[i]) begin
        rd_merged[8*i +: 8] = fwd_dat_q[8*i +: 8];
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all leave hreadyout high, so each may take a new transfer.
        if (accept) begin
          if (err_now) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WS_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    ahb3_hreadyout_o = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    ahb3_hresp_o     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    // Outside a read data phase the last returned word is held.
    ahb3_hrdata_o    = ((state_q == ST_DATA) && !hwrite_q) ? rd_merged : hrdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      hwrite_q  <= 1'b0;
      be_q      <= 4'b0000;
      idx_q     <= '0;
      fwd_vld_q <= 1'b0;
      fwd_be_q  <= 4'b0000;
      fwd_dat_q <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      hrdata_q <= ahb3_hrdata_o;
      if (accept) begin
        hwrite_q  <= ahb3_hwrite_i;
        be_q      <= be_now;
        idx_q     <= idx_now;
        fwd_vld_q <= fwd_hit;
        fwd_be_q  <= be_q;
        fwd_dat_q <= ahb3_hwdata_i;
      end
    end
  end

  // Burst, protection and lock carry no meaning for this endpoint.
  logic unused_ok;
  assign unused_ok = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, ahb3_htrans_i[0],
                       offset[PLEN-1:AW+2], offset[1:0]};

endmodule

// File: tb/tb_mpsoc_ahb3_ext_responder.sv
module tb_mpsoc_ahb3_ext_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel = 1'b0;
  logic        sel_ws3 = 1'b0;
  logic        hready_ovr = 1'b1;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [1:0]  htrans = 2'b00;

  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, resp0, resp3;
  logic        hsel0, hsel3, hrdy_i0, hrdy_i3;
  logic [31:0] rdata;
  logic        rdy, resp;

  always #5 clk = ~clk;

  assign hsel0   = hsel & ~sel_ws3;
  assign hsel3   = hsel & sel_ws3;
  assign hrdy_i0 = rdy0 & hready_ovr;
  assign hrdy_i3 = rdy3 & hready_ovr;
  assign rdata   = sel_ws3 ? rdata3 : rdata0;
  assign rdy     = sel_ws3 ? rdy3 : rdy0;
  assign resp    = sel_ws3 ? resp3 : resp0;

  mpsoc_ahb3_ext_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .ahb3_hsel_i(hsel0), .ahb3_haddr_i(haddr), .ahb3_hwdata_i(hwdata),
    .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize), .ahb3_hburst_i(3'b000), .ahb3_hprot_i(4'b0011),
    .ahb3_htrans_i(htrans), .ahb3_hmastlock_i(1'b0), .ahb3_hready_i(hrdy_i0),
    .ahb3_hrdata_o(rdata0), .ahb3_hreadyout_o(rdy0), .ahb3_hresp_o(resp0));

  mpsoc_ahb3_ext_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .ahb3_hsel_i(hsel3), .ahb3_haddr_i(haddr), .ahb3_hwdata_i(hwdata),
    .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize), .ahb3_hburst_i(3'b000), .ahb3_hprot_i(4'b0011),
    .ahb3_htrans_i(htrans), .ahb3_hmastlock_i(1'b0), .ahb3_hready_i(hrdy_i3),
    .ahb3_hrdata_o(rdata3), .ahb3_hreadyout_o(rdy3), .ahb3_hresp_o(resp3));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addr_phase(input bit wr, input logic [2:0] sz, input logic [31:0] a);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = a;
  endtask

  task automatic idle_phase();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = 32'h0;
  endtask

  // Single transfer followed by IDLE; entered and left at posedge+1.
  task automatic do_xfer(input bit ws3, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                         output int waits, output logic rsp_low, output logic timeout);
    sel_ws3 = ws3;
    addr_phase(wr, sz, a);
    @(posedge clk); #1;
    idle_phase();
    hwdata = wd;
    waits = 0; rsp_low = 1'b0; timeout = 1'b0;
    @(negedge clk);
    while (!rdy && !timeout) begin
      rsp_low = rsp_low | resp;
      waits++;
      if (waits > 40) timeout = 1'b1;
      @(negedge clk);
    end
    rd  = rdata;
    rsp = resp;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          ws3;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    int          exp_wait;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[18];

  logic [7:0] mdl [16][4];

  initial begin
    logic [31:0] rd;
    logic rsp, rsp_low, to;
    int waits;

    vt[0]  = '{0, 1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 0, 32'h0};
    vt[1]  = '{0, 0, 3'd2, 32'h8000_0010, 32'h0,         0, 0, 1, 32'hDEAD_BEEF};
    vt[2]  = '{0, 1, 3'd0, 32'h8000_0013, 32'hA5A5_A5A5, 0, 0, 0, 32'h0};
    vt[3]  = '{0, 0, 3'd2, 32'h8000_0010, 32'h0,         0, 0, 1, 32'hA5AD_BEEF};
    vt[4]  = '{0, 1, 3'd1, 32'h8000_0010, 32'h7788_1122, 0, 0, 0, 32'h0};
    vt[5]  = '{0, 0, 3'd0, 32'h8000_0012, 32'h0,         0, 0, 1, 32'hA5AD_1122};
    vt[6]  = '{0, 0, 3'd2, 32'h8000_1000, 32'h0,         1, 1, 0, 32'h0};
    vt[7]  = '{0, 0, 3'd1, 32'h8000_0001, 32'h0,         1, 1, 0, 32'h0};
    vt[8]  = '{0, 1, 3'd3, 32'h8000_0010, 32'hFFFF_FFFF, 1, 1, 0, 32'h0};
    vt[9]  = '{0, 1, 3'd2, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 1, 1, 0, 32'h0};
    vt[10] = '{0, 1, 3'd2, 32'h8000_0012, 32'hFFFF_FFFF, 1, 1, 0, 32'h0};
    vt[11] = '{0, 0, 3'd2, 32'h8000_0010, 32'h0,         0, 0, 1, 32'hA5AD_1122};
    vt[12] = '{0, 1, 3'd2, 32'h8000_0FFC, 32'hCAFE_F00D, 0, 0, 0, 32'h0};
    vt[13] = '{0, 0, 3'd2, 32'h8000_0FFC, 32'h0,         0, 0, 1, 32'hCAFE_F00D};
    vt[14] = '{1, 1, 3'd2, 32'h8000_0020, 32'h0BAD_F00D, 0, 3, 0, 32'h0};
    vt[15] = '{1, 0, 3'd2, 32'h8000_0020, 32'h0,         0, 3, 1, 32'h0BAD_F00D};
    vt[16] = '{1, 0, 3'd2, 32'h8000_1000, 32'h0,         1, 1, 0, 32'h0};
    vt[17] = '{1, 0, 3'd0, 32'h8000_0021, 32'h0,         0, 3, 1, 32'h0BAD_F00D};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst rdy0", 32'(rdy0), 32'd1);
    chk("rst resp0", 32'(resp0), 32'd0);
    chk("rst rdata0", rdata0, 32'h0);
    chk("rst rdy3", 32'(rdy3), 32'd1);
    chk("rst resp3", 32'(resp3), 32'd0);
    chk("rst rdata3", rdata3, 32'h0);
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 18; i++) begin
      do_xfer(vt[i].ws3, vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd, rd, rsp, waits, rsp_low, to);
      chk($sformatf("v%0d timeout", i), 32'(to), 32'd0);
      chk($sformatf("v%0d resp", i), 32'(rsp), 32'(vt[i].exp_err));
      chk($sformatf("v%0d waits", i), 32'(waits), 32'(vt[i].exp_wait));
      if (vt[i].exp_wait > 0) chk($sformatf("v%0d resp_low", i), 32'(rsp_low), 32'(vt[i].exp_err));
      if (vt[i].chk_rd) chk($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
    end

    // Back-to-back write then read of the same word, zero wait
    sel_ws3 = 1'b0;
    addr_phase(1'b1, 3'd2, 32'h8000_0040);
    @(posedge clk); #1;
    addr_phase(1'b0, 3'd2, 32'h8000_0040);
    hwdata = 32'h1234_5678;
    @(negedge clk);
    chk("b2b wr rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    idle_phase();
    @(negedge clk);
    chk("b2b rd rdy", 32'(rdy), 32'd1);
    chk("b2b rd resp", 32'(resp), 32'd0);
    chk("b2b fwd rdata", rdata, 32'h1234_5678);
    @(posedge clk); #1;

    // Partial forward: byte write merged with stale RAM lanes
    do_xfer(1'b0, 1'b1, 3'd2, 32'h8000_0044, 32'h1122_3344, rd, rsp, waits, rsp_low, to);
    addr_phase(1'b1, 3'd0, 32'h8000_0045);
    @(posedge clk); #1;
    addr_phase(1'b0, 3'd2, 32'h8000_0044);
    hwdata = 32'hFFFF_ABFF;
    @(posedge clk); #1;
    idle_phase();
    @(negedge clk);
    chk("partial fwd rdata", rdata, 32'h1122_AB44);
    @(posedge clk); #1;

    // hready_i low during DATA: the presented (erroring) transfer must not be taken
    addr_phase(1'b1, 3'd2, 32'h8000_0048);
    @(posedge clk); #1;
    addr_phase(1'b0, 3'd2, 32'h8000_1000);
    hwdata = 32'h5566_7788;
    hready_ovr = 1'b0;
    @(negedge clk);
    chk("stall data rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    idle_phase();
    hready_ovr = 1'b1;
    @(negedge clk);
    chk("stall no accept rdy", 32'(rdy), 32'd1);
    chk("stall no accept resp", 32'(resp), 32'd0);
    @(posedge clk); #1;
    do_xfer(1'b0, 1'b0, 3'd2, 32'h8000_0048, 32'h0, rd, rsp, waits, rsp_low, to);
    chk("stall write kept", rd, 32'h5566_7788);

    // Reset during WAIT of a write drops the write
    sel_ws3 = 1'b1;
    addr_phase(1'b1, 3'd2, 32'h8000_0020);
    @(posedge clk); #1;
    idle_phase();
    hwdata = 32'hFFFF_0000;
    @(negedge clk);
    chk("pre-rst wait rdy", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst rdy", 32'(rdy), 32'd1);
    chk("post-rst resp", 32'(resp), 32'd0);
    chk("post-rst rdata", rdata, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    do_xfer(1'b1, 1'b0, 3'd2, 32'h8000_0020, 32'h0, rd, rsp, waits, rsp_low, to);
    chk("post-rst readback", rd, 32'h0BAD_F00D);
    chk("post-rst waits", 32'(waits), 32'd3);

    // Random pipelined traffic on the zero-wait responder against a byte-level memory model
    begin
      bit pv, pwr, v, wr;
      logic [2:0] psz, sz;
      logic [31:0] paddr, a, wd;
      int idx, lane, pidx;
      logic [31:0] exp_word;
      sel_ws3 = 1'b0;
      pv = 1'b0; pwr = 1'b0; psz = 3'd0; paddr = 32'h0;
      for (int k = 0; k <= 600; k++) begin
        if (k < 16) begin
          v = 1'b1; wr = 1'b1; sz = 3'd2; idx = k; lane = 0;
        end else if (k == 600) begin
          v = 1'b0; wr = 1'b0; sz = 3'd0; idx = 0; lane = 0;
        end else begin
          v    = ($urandom_range(0, 3) != 0);
          wr   = $urandom_range(0, 1) == 1;
          sz   = 3'($urandom_range(0, 2));
          idx  = $urandom_range(0, 15);
          lane = (sz == 3'd0) ? $urandom_range(0, 3) : (sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
        end
        a = 32'h8000_0100 + 32'(idx * 4 + lane);
        if (v) addr_phase(wr, sz, a);
        else idle_phase();
        wd = $urandom;
        hwdata = wd;
        @(negedge clk);
        if (pv) begin
          pidx = int'((paddr - 32'h8000_0100) >> 2);
          chk($sformatf("rnd%0d rdy", k), 32'(rdy), 32'd1);
          chk($sformatf("rnd%0d resp", k), 32'(resp), 32'd0);
          if (pwr) begin
            for (int b = int'(paddr[1:0]); b < int'(paddr[1:0]) + (1 << psz); b++)
              mdl[pidx][b] = wd[8*b +: 8];
          end else begin
            exp_word = {mdl[pidx][3], mdl[pidx][2], mdl[pidx][1], mdl[pidx][0]};
            chk($sformatf("rnd%0d rdata @%h", k, paddr), rdata, exp_word);
          end
        end
        @(posedge clk); #1;
        pv = v; pwr = wr; psz = sz; paddr = a;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
